pe_row_sched: RTL
=================

Name: pe_row_sched

Overview:
- Sequencer for one kernel-row pass of a pe chain.
- Reads K weights from the global buffer, then streams one H x W ifmap in row-major order into the first PE.
- Drives the weight broadcast (clear, then K shifts) and the ifmap unicast with the alternating row indicator.
- Counts psum_vld pulses from the chain tail and raises done when the pass completes.

Parameters:
- G_BUF_ADDR_WIDTH, 10, global buffer address width.
- G_BUF_DATA_WIDTH, 8, buffer word width. Signed; sign-extended to DATA width.
- G_TOP_BITS, 2, integer bits of fixed-point data.
- G_BOT_BITS, 14, fraction bits of fixed-point data.
- G_KERNEL_SIZE, 5, K, weights per pass.
- G_IMAGE_HEIGHT, 28, H, ifmap rows.
- G_IMAGE_WIDTH, 28, W, ifmap columns.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  start a pass; sampled only in IDLE_S.
- w_base_i  in  G_BUF_ADDR_WIDTH  weight base address; captured on start.
- x_base_i  in  G_BUF_ADDR_WIDTH  ifmap base address; captured on start.
- buf_rd_en_o  out  1  buffer read strobe.
- buf_addr_o  out  G_BUF_ADDR_WIDTH  buffer read address.
- buf_data_i  in  G_BUF_DATA_WIDTH  read data, valid exactly 1 cycle after buf_rd_en_o.
- weight_clr_o  out  1  clear PE weight registers.
- weight_vld_o  out  1  weight shift strobe.
- weight_o  out  16  weight word.
- ifmap_vld_o  out  1  ifmap shift strobe.
- ifmap_row_o  out  1  row indicator.
- ifmap_o  out  16  ifmap word.
- psum_vld_i  in  1  psum valid from tail PE.
- busy_o  out  1  high in every state except IDLE_S.
- done_o  out  1  one-cycle pulse when the pass completes.

Behaviour:
- DATA width is G_TOP_BITS+G_BOT_BITS (16).
- Buffer words are sign-extended from G_BUF_DATA_WIDTH to DATA width; no shift.
- Reset: all outputs 0, state IDLE_S, all counters 0, captured bases 0.

States:
- IDLE_S: on start_i, capture the bases and go to CLR_S.
- CLR_S (1 cycle): weight_clr_o=1, then go to LOADW_S.
- LOADW_S:
  - Issue K reads at w_base+0..K-1, one per cycle.
  - weight_vld_o/weight_o follow each read by 1 cycle.
  - After the last read, go to STREAM_S. The last weight strobe overlaps the first STREAM_S cycle.
- STREAM_S:
  - Issue H*W reads at x_base+0..H*W-1, one per cycle, no bubbles.
  - ifmap_vld_o/ifmap_o follow each read by 1 cycle.
  - ifmap_row_o = 1 for even image rows (row 0 = 1), 0 for odd rows.
  - The row is derived from a row counter that wraps the column counter at W-1.
  - After the last read, go to DRAIN_S.
- DRAIN_S: wait until the psum count equals (H-K+1)*(W-K+1). Then pulse done_o and return to IDLE_S.

Counting and timing:
- Psum counter counts psum_vld_i in STREAM_S and DRAIN_S. It is cleared on start.
- Latency from start_i to the first buf_rd_en_o is 2 cycles (CLR_S, then the first LOADW_S read).

Boundary conditions:
- start_i outside IDLE_S is ignored.
- rst_i mid-pass: return to IDLE_S next cycle. All strobes go low that cycle; no done_o.
- Address arithmetic wraps modulo 2^G_BUF_ADDR_WIDTH.
- psum_vld_i in the same cycle as the final stream read is counted.
- Extra psum_vld_i after the target count is reached: saturate; no second done_o.
- psum_vld_i in IDLE_S is ignored.

Optional Feature:
- Macro: PE_ROW_SCHED_PERF_EN.
- With the macro: add outputs perf_cycles_o (32 bits) and perf_psums_o (16 bits).
  - perf_cycles_o counts busy cycles of the last pass.
  - perf_psums_o holds the final psum count.
  - Both are held until the next start and are 0 after reset.
- Without the macro: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package pe_pkg holds:
  - DATA_WIDTH_C;
  - the sched_state_t enum (IDLE_S, CLR_S, LOADW_S, STREAM_S, DRAIN_S);
  - the function out_count(H,W,K).
- One sub-module, pe_addr_gen: base + linear counter with a column/row split, producing row parity and a last flag.
- It is instantiated once and reused for the weight and stream phases.

Test Plan:
- K=3, H=W=4, start with w_base=0, x_base=16:
  - buf_addr_o = 0,1,2 then 16..31 contiguous;
  - weight_clr_o pulses once, 1 cycle before the first read.
- Buffer word 8'hFE:
  - weight_o = 16'hFFFE, one cycle after its read;
  - ifmap pixel 8'h7F gives ifmap_o = 16'h007F.
- Stream of 16 pixels with K=3, H=W=4:
  - ifmap_row_o = 1 for pixels 0-3, 0 for 4-7, 1 for 8-11, 0 for 12-15;
  - ifmap_vld_o high for exactly 16 cycles.
- Inject 4 psum_vld_i pulses (K=3, H=W=4 needs 2*2=4):
  - done_o pulses once, the cycle after the 4th pulse is counted;
  - busy_o then falls;
  - a 5th pulse gives no second done_o.
- Reset asserted mid-STREAM_S:
  - next cycle all strobes are 0 and busy_o=0;
  - a new start then restarts from CLR_S at the new bases.
- With PE_ROW_SCHED_PERF_EN and K=3, H=W=4: perf_psums_o=4 after done, and perf_cycles_o equals the measured busy_o-high count.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and helpers for the pe row scheduler: data width, FSM state encoding,
// and the number of valid convolution outputs per pass.
package pe_pkg;

  localparam int TOP_BITS_C   = 2;
  localparam int BOT_BITS_C   = 14;
  localparam int DATA_WIDTH_C = TOP_BITS_C + BOT_BITS_C;

  typedef enum logic [2:0] {
    IDLE_S   = 3'd0,
    CLR_S    = 3'd1,
    LOADW_S  = 3'd2,
    STREAM_S = 3'd3,
    DRAIN_S  = 3'd4
  } sched_state_t;

  // Valid (unpadded) output positions of a KxK kernel over an HxW image.
  function automatic int out_count(input int h, input int w, input int k);
    return (h - k + 1) * (w - k + 1);
  endfunction

endpackage

// File: rtl/pe_addr_gen.sv
// Linear address walker: base + count, split into column/row to give row parity, plus a last flag.
// Registered state; init_i wins over adv_i so a new phase can start in the cycle the old one ends.
module pe_addr_gen #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              init_i,
  input  logic              adv_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic [CNT_W-1:0]  cols_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              even_row_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  len_q, cols_q, lin_q, col_q;
  logic              odd_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q <= '0;
      len_q  <= '0;
      cols_q <= '0;
      lin_q  <= '0;
      col_q  <= '0;
      odd_q  <= 1'b0;
    end else if (init_i) begin
      base_q <= base_i;
      len_q  <= len_i;
      cols_q <= cols_i;
      lin_q  <= '0;
      col_q  <= '0;
      odd_q  <= 1'b0;
    end else if (adv_i) begin
      lin_q <= lin_q + 1'b1;
      if (col_q == cols_q - 1'b1) begin
        col_q <= '0;
        odd_q <= ~odd_q;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Truncation to ADDR_W gives the modulo-2^ADDR_W wrap.
  assign addr_o     = base_q + ADDR_W'(lin_q);
  assign even_row_o = ~odd_q;
  assign last_o     = (lin_q == len_q - 1'b1);

endmodule

// File: rtl/pe_row_sched.sv
// One kernel-row pass: clear + K weight loads, H*W ifmap stream, then wait for all psums and pulse done.
// First read 2 cycles after start; no backpressure. Optional perf counters under PE_ROW_SCHED_PERF_EN.
module pe_row_sched
  import pe_pkg::*;
#(
  parameter int G_BUF_ADDR_WIDTH = 10,
  parameter int G_BUF_DATA_WIDTH = 8,
  parameter int G_TOP_BITS       = TOP_BITS_C,
  parameter int G_BOT_BITS       = BOT_BITS_C,
  parameter int G_KERNEL_SIZE    = 5,
  parameter int G_IMAGE_HEIGHT   = 28,
  parameter int G_IMAGE_WIDTH    = 28
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic [G_BUF_ADDR_WIDTH-1:0]       w_base_i,
  input  logic [G_BUF_ADDR_WIDTH-1:0]       x_base_i,
  output logic                              buf_rd_en_o,
  output logic [G_BUF_ADDR_WIDTH-1:0]       buf_addr_o,
  input  logic [G_BUF_DATA_WIDTH-1:0]       buf_data_i,
  output logic                              weight_clr_o,
  output logic                              weight_vld_o,
  output logic [G_TOP_BITS+G_BOT_BITS-1:0]  weight_o,
  output logic                              ifmap_vld_o,
  output logic                              ifmap_row_o,
  output logic [G_TOP_BITS+G_BOT_BITS-1:0]  ifmap_o,
  input  logic                              psum_vld_i,
  output logic                              busy_o,
  output logic                              done_o
`ifdef PE_ROW_SCHED_PERF_EN
  ,
  output logic [31:0]                       perf_cycles_o,
  output logic [15:0]                       perf_psums_o
`endif
);

  localparam int DW       = G_TOP_BITS + G_BOT_BITS;
  localparam int NPIX_C   = G_IMAGE_HEIGHT * G_IMAGE_WIDTH;
  localparam int CNT_W    = $clog2(NPIX_C + 1);
  localparam int TARGET_C = out_count(G_IMAGE_HEIGHT, G_IMAGE_WIDTH, G_KERNEL_SIZE);

  sched_state_t                state_q, state_d;
  logic [G_BUF_ADDR_WIDTH-1:0] w_base_q, x_base_q;
  logic [CNT_W-1:0]            psum_cnt_q;
  logic                        wv_q, iv_q, row_q;

  logic                        rd_en, gen_init, gen_even, gen_last;
  logic [G_BUF_ADDR_WIDTH-1:0] gen_base, gen_addr;
  logic [CNT_W-1:0]            gen_len, gen_cols;
  logic [DW-1:0]               buf_sext;
  logic                        psum_full;

  assign psum_full = (psum_cnt_q == CNT_W'(TARGET_C));

  always_comb begin
    state_d  = state_q;
    rd_en    = 1'b0;
    gen_init = 1'b0;
    gen_base = w_base_q;
    gen_len  = CNT_W'(G_KERNEL_SIZE);
    gen_cols = CNT_W'(G_KERNEL_SIZE);
    case (state_q)
      IDLE_S:  if (start_i) state_d = CLR_S;
      CLR_S: begin
        gen_init = 1'b1;
        state_d  = LOADW_S;
      end
      LOADW_S: begin
        rd_en = 1'b1;
        // Re-arm the walker for the ifmap so streaming starts without a bubble.
        if (gen_last) begin
          gen_init = 1'b1;
          gen_base = x_base_q;
          gen_len  = CNT_W'(NPIX_C);
          gen_cols = CNT_W'(G_IMAGE_WIDTH);
          state_d  = STREAM_S;
        end
      end
      STREAM_S: begin
        rd_en = 1'b1;
        if (gen_last) state_d = DRAIN_S;
      end
      DRAIN_S: if (psum_full) state_d = IDLE_S;
      default: state_d = IDLE_S;
    endcase
  end

  pe_addr_gen #(
    .ADDR_W (G_BUF_ADDR_WIDTH),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .init_i     (gen_init),
    .adv_i      (rd_en),
    .base_i     (gen_base),
    .len_i      (gen_len),
    .cols_i     (gen_cols),
    .addr_o     (gen_addr),
    .even_row_o (gen_even),
    .last_o     (gen_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE_S;
      w_base_q   <= '0;
      x_base_q   <= '0;
      psum_cnt_q <= '0;
      wv_q       <= 1'b0;
      iv_q       <= 1'b0;
      row_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      wv_q    <= (state_q == LOADW_S);
      iv_q    <= (state_q == STREAM_S);
      row_q   <= (state_q == STREAM_S) && gen_even;
      if (state_q == IDLE_S && start_i) begin
        w_base_q   <= w_base_i;
        x_base_q   <= x_base_i;
        psum_cnt_q <= '0;
      end else if ((state_q == STREAM_S || state_q == DRAIN_S) && psum_vld_i && !psum_full) begin
        psum_cnt_q <= psum_cnt_q + 1'b1;
      end
    end
  end

  assign buf_sext     = {{(DW-G_BUF_DATA_WIDTH){buf_data_i[G_BUF_DATA_WIDTH-1]}}, buf_data_i};
  assign buf_rd_en_o  = rd_en;
  assign buf_addr_o   = rd_en ? gen_addr : '0;
  assign weight_clr_o = (state_q == CLR_S);
  assign weight_vld_o = wv_q;
  assign weight_o     = wv_q ? buf_sext : '0;
  assign ifmap_vld_o  = iv_q;
  assign ifmap_row_o  = row_q;
  assign ifmap_o      = iv_q ? buf_sext : '0;
  assign busy_o       = (state_q != IDLE_S);
  assign done_o       = (state_q == DRAIN_S) && psum_full;

`ifdef PE_ROW_SCHED_PERF_EN
  logic [31:0] perf_cycles_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_cycles_q <= '0;
    end else if (state_q == IDLE_S && start_i) begin
      perf_cycles_q <= '0;
    end else if (state_q != IDLE_S) begin
      perf_cycles_q <= perf_cycles_q + 1'b1;
    end
  end

  assign perf_cycles_o = perf_cycles_q;
  assign perf_psums_o  = 16'(psum_cnt_q);
`endif

endmodule
